dp_arbiter: RTL and testbench
=============================

Name: dp_arbiter

Overview:
- Round-robin arbiter sharing the single draw/compute datapath among up to N_REQ requester FSMs (background fill, sprite draw, network eval, ...).
- Each requester sees a private start/instruction/finished/result port with the same start-pulse / finished-level handshake the datapath presents, so requesters are unchanged whether wired direct or through the arbiter.
- Serialises one instruction at a time to the datapath and returns the datapath result to the issuing requester only.

Parameters:
- N_REQ, 4, number of requester ports (2..8).
- INSTR_W, 32, instruction width (matches INSTRUCTION_WIDTH).
- RESULT_W, 32, result width (matches RESULT_WIDTH).
- IDX_W, 2, width of grant index; must satisfy 2^IDX_W >= N_REQ.

Ports:
- clock  in  1  system clock, all logic on posedge.
- resetn  in  1  synchronous, active-low reset.
- req_start  in  N_REQ  per-requester start; bit i high = request from requester i.
- req_instruction  in  N_REQ*INSTR_W  packed instructions; slice i = requester i, held stable by requester until its finished returns high.
- req_finished  out  N_REQ  per-requester finished level; 1 = idle/result ready.
- req_result  out  RESULT_W  last datapath result, shared bus, valid for requester i when req_finished[i] rises.
- dp_start  out  1  start to datapath.
- dp_instruction  out  INSTR_W  instruction to datapath.
- dp_finished  in  1  datapath finished level.
- dp_result  in  RESULT_W  datapath result, valid while dp_finished=1.
- busy  out  1  high while an instruction is in flight (ISSUE..WAIT).
- grant_id  out  IDX_W  index of current/last granted requester.

Behaviour:
- Reset, resetn=0 sampled at a posedge:
  - state=IDLE, pending=0, req_finished=all 1s, req_result=0, dp_start=0, dp_instruction=0, busy=0, grant_id=N_REQ-1 (so the first round-robin search starts at 0).
  - Applies mid-operation too: the in-flight datapath op is abandoned and its result is never delivered.
- Request capture, every cycle, independent of state:
  - If req_start[i]=1 and pending[i]=0: set pending[i]=1 and req_finished[i]=0 (visible next cycle).
  - req_start[i] while pending[i]=1 is ignored (no double issue).
  - A requester dropping start after one cycle still gets served.
- Datapath contract relied on: dp_finished falls no later than the cycle after dp_start is first sampled high, and stays low until the result is valid.
- FSM:
  - IDLE: if any pending, pick the first pending index searching grant_id+1, grant_id+2, ... modulo N_REQ. Latch grant_id and dp_instruction = slice[grant]. Set dp_start=1, busy=1 -> ISSUE. Otherwise stay in IDLE.
  - ISSUE: dp_start=1 -> HOLD.
  - HOLD: dp_start=0 -> WAIT. dp_start is high for exactly 2 cycles per op.
  - WAIT: dp_start=0. When dp_finished=1: req_result=dp_result, pending[grant]=0, req_finished[grant]=1, busy=0 -> IDLE.
- Timing:
  - Request sampled at edge t -> dp_start high from t+1 if IDLE and no competitor.
  - Back-to-back ops have exactly 1 IDLE cycle between result delivery and the next dp_start.
- Instruction handling: dp_instruction holds its latched value from IDLE exit until the next grant; later changes on req_instruction are not reflected.
- Same-cycle events:
  - A new req_start[j] in the WAIT-complete cycle is captured and is eligible in the following IDLE.
  - req_start[grant] in the completion cycle: pending[grant] is cleared by completion in that cycle and is not set, so the start is dropped. Requesters must wait for finished before restarting.
- Fairness: each pending requester is served within N_REQ-1 other grants.
- req_result is only updated on completion; other requesters ignore it.

Test Plan:
- Reset then idle: resetn=0 for 2 cycles -> req_finished=4'b1111, dp_start=0, busy=0. No dp_start while req_start=0.
- Single request: req_start[2] pulsed 2 cycles, instr 32'h1000_0A05. Datapath model returns 32'hDEAD after 5 cycles -> dp_start high exactly 2 cycles, dp_instruction=32'h1000_0A05, req_finished[2] low then high with req_result=32'hDEAD, grant_id=2.
- Contention: req_start=4'b1111 same cycle, grant_id=3 at start -> grant order 0,1,2,3. Each gets its own instruction and result, with one IDLE cycle between ops.
- Round-robin fairness: requester 0 re-requests immediately after each finish while 1 is pending -> order 0,1,0,1. Requester 1 is never starved.
- Duplicate start: req_start[1] held high 6 cycles during its own op -> exactly one dp op issued for requester 1.
- Reset mid-op: resetn=0 during WAIT with 3 pending -> all pending cleared, req_finished=all 1s. A late dp_finished after reset causes no result delivery.

Source files
------------

// File: rtl/dp_arbiter_if.sv
// Requester-side and datapath-side handshake bundle for the shared datapath arbiter.
interface dp_arbiter_if #(
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned INSTR_W  = 32,
   parameter int unsigned RESULT_W = 32,
   parameter int unsigned IDX_W    = 2
);
   logic [N_REQ-1:0]         req_start;
   logic [N_REQ*INSTR_W-1:0] req_instruction;
   logic [N_REQ-1:0]         req_finished;
   logic [RESULT_W-1:0]      req_result;
   logic                     dp_start;
   logic [INSTR_W-1:0]       dp_instruction;
   logic                     dp_finished;
   logic [RESULT_W-1:0]      dp_result;
   logic                     busy;
   logic [IDX_W-1:0]         grant_id;

   // Arbiter side
   modport slave (
      input  req_start, req_instruction, dp_finished, dp_result,
      output req_finished, req_result, dp_start, dp_instruction, busy, grant_id
   );

   // Requesters plus datapath side
   modport master (
      output req_start, req_instruction, dp_finished, dp_result,
      input  req_finished, req_result, dp_start, dp_instruction, busy, grant_id
   );
endinterface

// File: rtl/dp_arbiter.sv
// Round-robin arbiter sharing one start/finished datapath among N_REQ requesters.
// One instruction in flight at a time; the result goes back to the issuer only.
module dp_arbiter #(
   parameter int unsigned N_REQ    = 4,
   parameter int unsigned INSTR_W  = 32,
   parameter int unsigned RESULT_W = 32,
   parameter int unsigned IDX_W    = 2
) (
   input  logic        clock,
   input  logic        resetn,
   dp_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_HOLD  = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   state_t              r_state;
   logic [N_REQ-1:0]    r_pending;
   logic [N_REQ-1:0]    r_req_finished;
   logic [RESULT_W-1:0] r_req_result;
   logic                r_dp_start;
   logic [INSTR_W-1:0]  r_dp_instruction;
   logic                r_busy;
   logic [IDX_W-1:0]    r_grant_id;

   logic                w_found;
   logic [IDX_W-1:0]    w_pick;
   logic [IDX_W-1:0]    w_cand;

   // First pending requester after the last grant, wrapping modulo N_REQ
   always_comb begin
      w_found = 1'b0;
      w_pick  = r_grant_id;
      w_cand  = r_grant_id;
      for (int unsigned k = 1; k <= N_REQ; k++) begin
         w_cand = IDX_W'((32'(r_grant_id) + k) % N_REQ);
         if (!w_found && r_pending[w_cand]) begin
            w_found = 1'b1;
            w_pick  = w_cand;
         end
      end
   end

   // Request capture plus issue/hold/wait sequencing of the shared datapath
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state          <= S_IDLE;
         r_pending        <= '0;
         r_req_finished   <= '1;
         r_req_result     <= '0;
         r_dp_start       <= 1'b0;
         r_dp_instruction <= '0;
         r_busy           <= 1'b0;
         r_grant_id       <= IDX_W'(N_REQ - 1);
      end else begin
         // A start is only taken while that requester has nothing outstanding
         r_pending      <= r_pending | bus.req_start;
         r_req_finished <= r_req_finished & ~(bus.req_start & ~r_pending);

         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_grant_id       <= w_pick;
                  r_dp_instruction <= bus.req_instruction[32'(w_pick)*INSTR_W +: INSTR_W];
                  r_dp_start       <= 1'b1;
                  r_busy           <= 1'b1;
                  r_state          <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_dp_start <= 1'b1;
               r_state    <= S_HOLD;
            end
            S_HOLD: begin
               r_dp_start <= 1'b0;
               r_state    <= S_WAIT;
            end
            S_WAIT: begin
               r_dp_start <= 1'b0;
               if (bus.dp_finished) begin
                  // Completion wins over a same-cycle restart from the granted requester
                  r_req_result               <= bus.dp_result;
                  r_pending[r_grant_id]      <= 1'b0;
                  r_req_finished[r_grant_id] <= 1'b1;
                  r_busy                     <= 1'b0;
                  r_state                    <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_finished   = r_req_finished;
   assign bus.req_result     = r_req_result;
   assign bus.dp_start       = r_dp_start;
   assign bus.dp_instruction = r_dp_instruction;
   assign bus.busy           = r_busy;
   assign bus.grant_id       = r_grant_id;

endmodule

// File: tb/tb_dp_arbiter.sv
// Bench for dp_arbiter: directed scenarios plus randomized requesters against a
// transaction-level reference model and a latency-randomized datapath model.
module tb_dp_arbiter;
   localparam int unsigned N  = 4;
   localparam int unsigned IW = 32;
   localparam int unsigned RW = 32;
   localparam int unsigned XW = 2;

   logic clock = 1'b0;
   logic resetn;
   always #5 clock = ~clock;

   dp_arbiter_if #(.N_REQ(N), .INSTR_W(IW), .RESULT_W(RW), .IDX_W(XW)) bus ();

   dp_arbiter #(.N_REQ(N), .INSTR_W(IW), .RESULT_W(RW), .IDX_W(XW)) dut (
      .clock (clock),
      .resetn(resetn),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_err    = 0;

   logic [IW-1:0] instr_held [N];
   always_comb begin
      for (int i = 0; i < int'(N); i++) bus.req_instruction[i*IW +: IW] = instr_held[i];
   end

   function automatic logic [RW-1:0] dp_func(input logic [IW-1:0] x);
      return {x[15:0], x[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Datapath model: finished drops on the start rising edge, result after a latency
   logic          dp_override = 1'b0;
   logic          dp_rand     = 1'b0;
   int            dp_lat      = 5;
   initial begin
      logic          prev;
      logic          active;
      int            cnt;
      logic [IW-1:0] op;
      prev = 1'b0; active = 1'b0; cnt = 0; op = '0;
      bus.dp_finished = 1'b1;
      bus.dp_result   = '0;
      forever begin
         @(negedge clock);
         if (bus.dp_start === 1'b1 && prev === 1'b0 && !active) begin
            active = 1'b1;
            bus.dp_finished = 1'b0;
            cnt = dp_rand ? int'($urandom_range(0, 6)) : dp_lat;
            op  = bus.dp_instruction;
         end else if (active) begin
            if (cnt > 0) cnt--;
            else begin
               bus.dp_finished = 1'b1;
               bus.dp_result   = dp_override ? 32'h0000_DEAD : dp_func(op);
               active = 1'b0;
            end
         end
         prev = bus.dp_start;
      end
   end

   // Reference model: pending set, last winner, and cycles since the grant
   logic [N-1:0]  m_pending;
   logic [N-1:0]  m_finished;
   logic [RW-1:0] m_result;
   logic [IW-1:0] m_instr;
   int            m_grant;
   int            m_age;
   int            waits [N];
   logic [N-1:0]  old_pend;
   bit            found;

   always @(posedge clock) begin
      if (!resetn) begin
         m_pending = '0; m_finished = '1; m_result = '0; m_instr = '0;
         m_grant = N - 1; m_age = 0;
         for (int j = 0; j < int'(N); j++) waits[j] = 0;
      end else begin
         old_pend = m_pending;
         for (int i = 0; i < int'(N); i++) begin
            if (bus.req_start[i] && !old_pend[i]) begin
               m_pending[i]  = 1'b1;
               m_finished[i] = 1'b0;
            end
         end
         if (m_age == 0) begin
            found = 1'b0;
            for (int k = 1; k <= int'(N); k++) begin
               if (!found && old_pend[(m_grant + k) % N]) begin
                  found   = 1'b1;
                  m_grant = (m_grant + k) % N;
               end
            end
            if (found) begin
               m_instr = bus.req_instruction[m_grant*IW +: IW];
               m_age   = 1;
               chk("fairness_wait", 32'(waits[m_grant] <= int'(N) - 1), 32'd1);
               for (int j = 0; j < int'(N); j++)
                  if (j != m_grant && old_pend[j]) waits[j]++;
               waits[m_grant] = 0;
            end
         end else if (m_age < 3) begin
            m_age++;
         end else if (bus.dp_finished) begin
            m_result            = bus.dp_result;
            m_pending[m_grant]  = 1'b0;
            m_finished[m_grant] = 1'b1;
            m_age               = 0;
         end
      end
   end

   // Per-cycle compare of every DUT output against the model
   logic         chk_en = 1'b0;
   logic         e2e_en = 1'b0;
   logic [N-1:0] prev_fin = '1;
   always @(negedge clock) begin
      if (chk_en) begin
         chk("req_finished",   32'(bus.req_finished),   32'(m_finished));
         chk("dp_start",       32'(bus.dp_start),       32'(m_age == 1 || m_age == 2));
         chk("busy",           32'(bus.busy),           32'(m_age != 0));
         chk("grant_id",       32'(bus.grant_id),       32'(m_grant));
         chk("dp_instruction", 32'(bus.dp_instruction), 32'(m_instr));
         chk("req_result",     32'(bus.req_result),     32'(m_result));
         for (int i = 0; i < int'(N); i++)
            if (e2e_en && !prev_fin[i] && bus.req_finished[i])
               chk("e2e_result", 32'(bus.req_result), 32'(dp_func(instr_held[i])));
         prev_fin = bus.req_finished;
      end
   end

   task automatic do_reset();
      @(negedge clock);
      resetn = 1'b0;
      bus.req_start = '0;
      @(negedge clock);
      @(negedge clock);
      chk("rst_finished", 32'(bus.req_finished), 32'h0000_000F);
      chk("rst_dp_start", 32'(bus.dp_start),     32'd0);
      chk("rst_busy",     32'(bus.busy),         32'd0);
      chk("rst_grant",    32'(bus.grant_id),     32'd3);
      chk("rst_result",   32'(bus.req_result),   32'd0);
      resetn = 1'b1;
   endtask

   task automatic wait_idle(input int budget);
      int c;
      for (c = 0; c < budget; c++) begin
         @(negedge clock);
         if (&bus.req_finished && !bus.busy) break;
      end
      if (c == budget) begin
         n_checks++; n_err++;
         $display("FAIL drain_timeout actual=busy required=idle at %0t", $time);
      end
   endtask

   int order_q[$];
   task automatic run_ops(input logic [N-1:0] mask, input int hold, input int stop_at,
                          input int budget, output int n, output int gaps);
      logic prev;
      prev = bus.dp_start; n = 0; gaps = 0;
      order_q.delete();
      for (int c = 0; c < budget; c++) begin
         bus.req_start = (c < hold) ? mask : '0;
         @(negedge clock);
         if (bus.dp_start && !prev) begin
            n++;
            order_q.push_back(int'(bus.grant_id));
         end else if (!bus.busy && n >= 1 && n < stop_at) gaps++;
         prev = bus.dp_start;
         if (stop_at > 0 && n >= stop_at && !bus.busy) break;
      end
      bus.req_start = '0;
   endtask

   function automatic int order_at(input int k);
      return (k < order_q.size()) ? order_q[k] : -1;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running required=finished at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, gaps, cnt;
      bit saw_low, seen;
      int hold [N];
      bit was_idle [N];
      resetn = 1'b0;
      bus.req_start = '0;
      for (int i = 0; i < int'(N); i++) begin instr_held[i] = '0; hold[i] = 0; was_idle[i] = 1'b1; end

      // Reset and quiet idle
      do_reset();
      chk_en = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         chk("idle_no_start", 32'(bus.dp_start), 32'd0);
      end

      // Single request from requester 2, fixed datapath answer
      dp_lat = 5; dp_override = 1'b1;
      instr_held[2] = 32'h1000_0A05;
      cnt = 0; saw_low = 1'b0;
      for (int c = 0; c < 25; c++) begin
         bus.req_start = (c < 2) ? 4'b0100 : 4'b0000;
         @(negedge clock);
         if (bus.dp_start) begin
            cnt++;
            chk("single_instr", bus.dp_instruction, 32'h1000_0A05);
         end
         if (!bus.req_finished[2]) saw_low = 1'b1;
      end
      chk("single_start_cycles", 32'(cnt),                 32'd2);
      chk("single_fin_low",      32'(saw_low),             32'd1);
      chk("single_fin_high",     32'(bus.req_finished[2]), 32'd1);
      chk("single_result",       bus.req_result,           32'h0000_DEAD);
      chk("single_grant",        32'(bus.grant_id),        32'd2);
      dp_override = 1'b0;

      // All four at once from reset: 0,1,2,3 with one idle cycle between ops
      e2e_en = 1'b1;
      do_reset();
      for (int i = 0; i < int'(N); i++) instr_held[i] = 32'hC0DE_0000 + 32'(i) * 32'h111;
      run_ops(4'b1111, 1, 4, 200, n, gaps);
      chk("cont_ops", 32'(n), 32'd4);
      for (int k = 0; k < 4; k++) chk("cont_order", 32'(order_at(k)), 32'(k));
      chk("cont_gaps", 32'(gaps), 32'd3);

      // Requester 0 restarting immediately must not starve requester 1
      do_reset();
      run_ops(4'b0011, 1000, 4, 300, n, gaps);
      chk("fair_ops", 32'(n), 32'd4);
      chk("fair_o0", 32'(order_at(0)), 32'd0);
      chk("fair_o1", 32'(order_at(1)), 32'd1);
      chk("fair_o2", 32'(order_at(2)), 32'd0);
      chk("fair_o3", 32'(order_at(3)), 32'd1);
      wait_idle(200);

      // Start held during its own op issues exactly once
      run_ops(4'b0010, 6, 0, 40, n, gaps);
      chk("dup_ops",   32'(n),           32'd1);
      chk("dup_grant", 32'(order_at(0)), 32'd1);
      wait_idle(100);

      // Reset during WAIT with three pending; late finished is not delivered
      e2e_en = 1'b0;
      dp_lat = 8;
      seen = 1'b0;
      for (int c = 0; c < 50; c++) begin
         bus.req_start = (c < 1) ? 4'b0111 : 4'b0000;
         @(negedge clock);
         if (bus.dp_start) seen = 1'b1;
         else if (seen && bus.busy) break;
      end
      chk("midop_busy", 32'(bus.busy), 32'd1);
      resetn = 1'b0;
      @(negedge clock);
      @(negedge clock);
      chk("midrst_finished", 32'(bus.req_finished), 32'h0000_000F);
      chk("midrst_busy",     32'(bus.busy),         32'd0);
      chk("midrst_start",    32'(bus.dp_start),     32'd0);
      resetn = 1'b1;
      cnt = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clock);
         if (bus.dp_start || !(&bus.req_finished)) cnt++;
      end
      chk("late_no_activity", 32'(cnt),            32'd0);
      chk("late_result",      bus.req_result,      32'd0);

      // Randomized requesters and datapath latency
      e2e_en = 1'b1; dp_rand = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clock);
         for (int i = 0; i < int'(N); i++) begin
            if (bus.req_start[i]) begin
               if (hold[i] > 0) hold[i]--;
               if (hold[i] == 0) bus.req_start[i] = 1'b0;
            end else if (!m_pending[i] && was_idle[i] && $urandom_range(0, 3) == 0) begin
               instr_held[i] = $urandom;
               bus.req_start[i] = 1'b1;
               hold[i] = int'($urandom_range(1, 5));
            end
            was_idle[i] = !m_pending[i];
         end
      end
      bus.req_start = '0;
      wait_idle(300);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end
endmodule
